ncr5380x: RTL and testbench

Parametrised NCR 5380-compatible SCSI initiator front-end for N simulated targets. It replaces fixed two-target wiring with:
- a generic target mux;
- a four-state DMA handshake engine with EOP;
- a real interrupt path (phase mismatch, end of DMA, busy loss).

It sits between the CPU bus decode (A4..A6 as `bus_rs`, A9 as `dack`) and the `scsi` target instances.

---
 rtl/ncr5380x_pkg.sv | 29 ++
 rtl/ncr5380x_dma.sv | 46 ++++
 rtl/ncr5380x.sv | 124 ++++++++++++
 tb/tb_ncr5380x.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ncr5380x_pkg.sv
// ncr5380x_pkg: register addresses, control bit indices and DMA state encoding
package ncr5380x_pkg;
  localparam logic [2:0] R_CUR = 3'd0;
  localparam logic [2:0] R_ICR = 3'd1;
  localparam logic [2:0] R_MR  = 3'd2;
  localparam logic [2:0] R_TCR = 3'd3;
  localparam logic [2:0] R_CSR = 3'd4;
  localparam logic [2:0] R_BSR = 3'd5;
  localparam logic [2:0] R_IDR = 3'd6;
  localparam logic [2:0] R_RPI = 3'd7;
  localparam logic [2:0] W_ODR = 3'd0;
  localparam logic [2:0] W_ICR = 3'd1;
  localparam logic [2:0] W_MR  = 3'd2;
  localparam logic [2:0] W_TCR = 3'd3;
  localparam logic [2:0] W_SDS = 3'd5;
  localparam logic [2:0] W_SDI = 3'd7;
  localparam int MR_ARB  = 0;
  localparam int MR_DMA  = 1;
  localparam int MR_MBSY = 2;
  localparam int MR_EOPI = 3;
  localparam int ICR_DBUS = 0;
  localparam int ICR_ATN  = 1;
  localparam int ICR_SEL  = 2;
  localparam int ICR_BSY  = 3;
  localparam int ICR_ACK  = 4;
  localparam int TCR_IO  = 0;
  localparam int TCR_MSG = 2;
  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_ACK, S_DONE} dma_state_e;
endpackage

// File: rtl/ncr5380x_dma.sv
// ncr5380x_dma: DMA handshake FSM with EOP latch and ce-gated ACK register
import ncr5380x_pkg::*;
module ncr5380x_dma (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  input  logic en,
  input  logic abort,
  input  logic arm,
  input  logic dma_pulse,
  input  logic req,
  input  logic pmatch,
  input  logic eop,
  output logic drq,
  output logic ack_q,
  output logic pm_evt,
  output logic done_entry,
  output logic end_dma
);
  dma_state_e state, nxt;
  logic eop_q;
  // state register and EOP latch, which forgets on every return to IDLE
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= S_IDLE;
      eop_q <= 1'b0;
    end else begin
      state <= nxt;
      eop_q <= (nxt == S_IDLE) ? 1'b0 : eop_q | (eop && (state == S_ARMED || state == S_ACK));
    end
  // ACK to the bus follows the ACK state at the SCSI-side rate
  always_ff @(posedge clk or posedge reset)
    if (reset) ack_q <= 1'b0;
    else if (ce) ack_q <= state == S_ACK;
  // next state and handshake outputs; disable or bus reset wins over everything
  always_comb begin
    drq = state == S_ARMED && req && pmatch;
    pm_evt = state == S_ARMED && req && !pmatch;
    nxt = (!en || abort) ? S_IDLE :
          (state == S_IDLE && arm) ? S_ARMED :
          (state == S_ARMED && dma_pulse && req) ? S_ACK :
          (state == S_ACK && !req) ? ((eop_q || eop) ? S_DONE : S_ARMED) : state;
    done_entry = nxt == S_DONE && state != S_DONE;
  end
  assign end_dma = state == S_DONE;
endmodule

// File: rtl/ncr5380x.sv
// ncr5380x: NCR 5380 initiator front-end for N targets; NCR5380X_IRQ_EN enables the interrupt latch
import ncr5380x_pkg::*;
module ncr5380x #(
  parameter int NUM_TARGETS = 2,
  parameter int DW = 8,
  localparam int SW = NUM_TARGETS > 1 ? $clog2(NUM_TARGETS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ce,
  input  logic                    bus_cs,
  input  logic                    bus_we,
  input  logic [2:0]              bus_rs,
  input  logic                    dack,
  input  logic                    eop,
  input  logic [DW-1:0]           wdata,
  output logic [DW-1:0]           rdata,
  output logic                    irq,
  output logic                    drq,
  output logic                    scsi_rst,
  output logic                    scsi_sel,
  output logic                    scsi_atn,
  output logic                    scsi_ack,
  output logic [DW-1:0]           scsi_dout,
  input  logic [NUM_TARGETS-1:0]  tgt_bsy,
  input  logic [NUM_TARGETS-1:0]  tgt_req,
  input  logic [NUM_TARGETS-1:0]  tgt_msg,
  input  logic [NUM_TARGETS-1:0]  tgt_cd,
  input  logic [NUM_TARGETS-1:0]  tgt_io,
  input  logic [NUM_TARGETS*DW-1:0] tgt_dout,
  output logic [SW-1:0]           tgt_sel_idx
);
  localparam logic [DW-1:0] IDLE_DIN = DW'(8'h55);
  logic [7:0] mr;
  logic [3:0] tcr;
  logic icr_rst;
  logic [4:0] icr_lo;
  logic [DW-1:0] dout, din, cur;
  logic [3:0] lvl, lvl_q, lvl_qq, edg;
  logic dma_wr, dma_rd, reg_wr, reg_rd, rpi_rd, arm;
  logic req, msg, cd, io, any_bsy, scsi_bsy, pmatch;
  logic [SW-1:0] sel_q;
  logic act_q, busy_loss, busy_err;
  logic ack_q, pm_evt, done_entry, end_dma;
  logic [7:0] csr, bsr;
  assign lvl = {bus_cs & bus_we & dack, bus_cs & ~bus_we & dack, bus_cs & bus_we & ~dack, bus_cs & ~bus_we & ~dack};
  assign edg = lvl_q & ~lvl_qq;
  assign dma_wr = edg[3];
  assign dma_rd = edg[2] & ~edg[3];
  assign reg_wr = edg[1] & ~|edg[3:2];
  assign reg_rd = edg[0] & ~|edg[3:1];
  assign rpi_rd = reg_rd && bus_rs == R_RPI;
  assign arm = reg_wr && (bus_rs == W_SDS || bus_rs == W_SDI);
  // strobe levels are registered twice so each rising edge yields one pulse
  always_ff @(posedge clk or posedge reset)
    if (reset) {lvl_q, lvl_qq} <= '0;
    else {lvl_q, lvl_qq} <= {lvl, lvl_q};
  // lowest busy slot wins; with nobody busy the bus floats to the idle pattern
  always_comb begin
    tgt_sel_idx = '0;
    {req, msg, cd, io} = 4'b0;
    din = IDLE_DIN;
    for (int k = NUM_TARGETS - 1; k >= 0; k--)
      if (tgt_bsy[k]) begin
        tgt_sel_idx = SW'(k);
        {req, msg, cd, io} = {tgt_req[k], tgt_msg[k], tgt_cd[k], tgt_io[k]};
        din = tgt_dout[k*DW +: DW];
      end
  end
  assign any_bsy = |tgt_bsy;
  assign busy_loss = mr[MR_MBSY] & act_q & ~tgt_bsy[sel_q];
  // register file and busy-loss tracking of the previously active slot
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mr <= '0;
      tcr <= '0;
      icr_rst <= 1'b0;
      icr_lo <= '0;
      dout <= '0;
      sel_q <= '0;
      act_q <= 1'b0;
      busy_err <= 1'b0;
    end else begin
      if (reg_wr && bus_rs == W_MR) mr <= wdata[7:0];
      if (reg_wr && bus_rs == W_TCR) tcr <= wdata[3:0];
      if (reg_wr && bus_rs == W_ICR) {icr_rst, icr_lo} <= {wdata[7], wdata[4:0]};
      if (dma_wr || (reg_wr && bus_rs == W_ODR)) dout <= wdata;
      sel_q <= tgt_sel_idx;
      act_q <= any_bsy;
      busy_err <= busy_loss | (busy_err & ~rpi_rd);
    end
  ncr5380x_dma u_dma (
    .clk(clk), .reset(reset), .ce(ce), .en(mr[MR_DMA]), .abort(icr_rst), .arm(arm),
    .dma_pulse(dma_wr | dma_rd), .req(req), .pmatch(pmatch), .eop(eop),
    .drq(drq), .ack_q(ack_q), .pm_evt(pm_evt), .done_entry(done_entry), .end_dma(end_dma)
  );
`ifdef NCR5380X_IRQ_EN
  // interrupt latch: mismatch, DMA end or busy loss set it; reg-7 read or bus reset clear it
  always_ff @(posedge clk or posedge reset)
    if (reset) irq <= 1'b0;
    else irq <= (rpi_rd || icr_rst) ? 1'b0 :
                irq | (pm_evt & mr[MR_DMA]) | (done_entry & mr[MR_EOPI]) | busy_loss;
`else
  assign irq = 1'b0 & (pm_evt | done_entry);
`endif
  assign pmatch = tcr[TCR_MSG:TCR_IO] == {msg, cd, io};
  assign scsi_bsy = icr_lo[ICR_BSY] | any_bsy | mr[MR_ARB];
  assign scsi_rst = icr_rst;
  assign scsi_sel = icr_lo[ICR_SEL];
  assign scsi_atn = icr_lo[ICR_ATN];
  assign scsi_ack = icr_lo[ICR_ACK] | ack_q;
  assign scsi_dout = dout;
  assign cur = (icr_lo[ICR_DBUS] | mr[MR_ARB]) ? dout : din;
  assign csr = {icr_rst, scsi_bsy, req, msg, cd, io, scsi_sel, 1'b0};
  assign bsr = {end_dma, drq, 1'b0, irq, pmatch, busy_err, scsi_atn, scsi_ack};
  // combinational host read mux; any DMA access sees the current data
  always_comb
    rdata = (dack || bus_rs == R_CUR || bus_rs == R_IDR) ? cur :
            bus_rs == R_ICR ? DW'({icr_rst, mr[MR_ARB], 1'b0, icr_lo}) :
            bus_rs == R_MR  ? DW'(mr) :
            bus_rs == R_TCR ? DW'(tcr) :
            bus_rs == R_CSR ? DW'(csr) :
            bus_rs == R_BSR ? DW'(bsr) : '1;
endmodule

// File: tb/tb_ncr5380x.sv
// tb_ncr5380x: scoreboard bench with directed scenarios and a randomized register/target model
module tb_ncr5380x;
  localparam int N = 2;
  localparam int DW = 8;
`ifdef NCR5380X_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif
  logic clk = 0, reset = 1, ce = 0, bus_cs = 0, bus_we = 0, dack = 0, eop = 0;
  logic [2:0] bus_rs = 0;
  logic [DW-1:0] wdata = 0;
  logic [DW-1:0] rdata, scsi_dout;
  logic irq, drq, scsi_rst, scsi_sel, scsi_atn, scsi_ack;
  logic [N-1:0] tgt_bsy = 0, tgt_req = 0, tgt_msg = 0, tgt_cd = 0, tgt_io = 0;
  logic [N*DW-1:0] tgt_dout = 0;
  logic [0:0] tgt_sel_idx;
  int checks = 0, errors = 0;
  logic [7:0] m_mr, m_icr, m_odr;
  logic [3:0] m_tcr;

  typedef struct {
    string name;
    int sig;
    logic [7:0] mask;
    logic [7:0] exp;
  } exp_t;
  exp_t sb[$];
  event chk_ev;

  ncr5380x #(.NUM_TARGETS(N), .DW(DW)) dut (
    .clk(clk), .reset(reset), .ce(ce), .bus_cs(bus_cs), .bus_we(bus_we), .bus_rs(bus_rs),
    .dack(dack), .eop(eop), .wdata(wdata), .rdata(rdata), .irq(irq), .drq(drq),
    .scsi_rst(scsi_rst), .scsi_sel(scsi_sel), .scsi_atn(scsi_atn), .scsi_ack(scsi_ack),
    .scsi_dout(scsi_dout), .tgt_bsy(tgt_bsy), .tgt_req(tgt_req), .tgt_msg(tgt_msg),
    .tgt_cd(tgt_cd), .tgt_io(tgt_io), .tgt_dout(tgt_dout), .tgt_sel_idx(tgt_sel_idx)
  );

  always #5 clk = ~clk;
  initial forever @(negedge clk) ce = ~ce;
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [7:0] observe(input int s);
    case (s)
      0: return rdata;
      1: return {7'b0, irq};
      2: return {7'b0, drq};
      3: return {7'b0, scsi_ack};
      4: return {7'b0, tgt_sel_idx};
      5: return scsi_dout;
      default: return {7'b0, scsi_sel};
    endcase
  endfunction

  initial begin
    exp_t e;
    logic [7:0] act;
    forever begin
      @(chk_ev);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        act = observe(e.sig) & e.mask;
        checks++;
        if (act !== (e.exp & e.mask)) begin
          errors++;
          $display("FAIL %s: got %02h expected %02h", e.name, act, e.exp & e.mask);
        end
      end
    end
  end

  task automatic expect_v(input string name, input int sig, input logic [7:0] exp, input logic [7:0] mask = 8'hff);
    sb.push_back('{name, sig, mask, exp});
    -> chk_ev;
    #1;
  endtask

  task automatic wait_sig(input string name, input int sig, input logic [7:0] val, input int budget);
    for (int i = 0; i < budget && observe(sig) !== val; i++) @(negedge clk);
    expect_v(name, sig, val);
  endtask

  task automatic wr(input logic [2:0] rs, input logic [7:0] d, input bit dk = 0);
    @(negedge clk);
    bus_cs = 1; bus_we = 1; bus_rs = rs; wdata = d; dack = dk;
    repeat (3) @(negedge clk);
    bus_cs = 0; dack = 0;
    @(negedge clk);
  endtask

  task automatic rd(input string name, input logic [2:0] rs, input logic [7:0] exp, input bit dk = 0, input logic [7:0] mask = 8'hff);
    @(negedge clk);
    bus_cs = 1; bus_we = 0; bus_rs = rs; dack = dk;
    #1;
    expect_v(name, 0, exp, mask);
    repeat (3) @(negedge clk);
    bus_cs = 0; dack = 0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; bus_cs = 0; dack = 0; eop = 0;
    tgt_bsy = 0; tgt_req = 0; tgt_msg = 0; tgt_cd = 0; tgt_io = 0; tgt_dout = 0;
    m_mr = 0; m_icr = 0; m_odr = 0; m_tcr = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
  endtask

  function automatic int first_busy();
    for (int k = 0; k < N; k++) if (tgt_bsy[k]) return k;
    return -1;
  endfunction

  function automatic logic [7:0] model_rd(input logic [2:0] rs, input bit dk);
    int a;
    logic [7:0] din, cur;
    logic r, m, c, i;
    a = first_busy();
    din = (a < 0) ? 8'h55 : tgt_dout[a*8 +: 8];
    r = a >= 0 && tgt_req[a];
    m = a >= 0 && tgt_msg[a];
    c = a >= 0 && tgt_cd[a];
    i = a >= 0 && tgt_io[a];
    cur = (m_icr[0] || m_mr[0]) ? m_odr : din;
    if (dk || rs == 0 || rs == 6) return cur;
    case (rs)
      1: return {m_icr[7], m_mr[0], 1'b0, m_icr[4:0]};
      4: return {m_icr[7], m_icr[3] | (a >= 0) | m_mr[0], r, m, c, i, m_icr[2], 1'b0};
      5: return {4'b0, m_tcr[2:0] == {m, c, i}, 1'b0, m_icr[1], m_icr[4]};
      default: return 8'hff;
    endcase
  endfunction

  initial begin
    logic [7:0] b, d;
    logic [2:0] rs;
    int a, op;
    bit dk;
    do_reset();
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq_direct: got %b", irq); end
    checks++;
    if (drq !== 1'b0) begin errors++; $display("FAIL rst_drq_direct: got %b", drq); end
    checks++;
    if (scsi_ack !== 1'b0) begin errors++; $display("FAIL rst_ack_direct: got %b", scsi_ack); end
    checks++;
    if (scsi_dout !== 8'h00) begin errors++; $display("FAIL rst_dout_direct: got %02h", scsi_dout); end
    checks++;
    if (tgt_sel_idx !== 1'b0) begin errors++; $display("FAIL rst_idx_direct: got %b", tgt_sel_idx); end
    expect_v("rst_irq", 1, 8'h00);
    expect_v("rst_drq", 2, 8'h00);
    expect_v("rst_ack", 3, 8'h00);
    expect_v("rst_dout", 5, 8'h00);
    rd("rst_bsr", 5, 8'h08);
    rd("rst_icr", 1, 8'h00);

    tgt_bsy = 2'b10;
    wr(1, 8'h04);
    rd("sel_csr", 4, 8'h42);
    expect_v("sel_idx1", 4, 8'h01);
    expect_v("sel_line", 6, 8'h01);
    rd("sel_icr", 1, 8'h04);

    do_reset();
    tgt_bsy = 2'b01; tgt_io = 2'b01; tgt_dout = 16'h00A5;
    wr(2, 8'h02); wr(3, 8'h01); wr(7, 8'h00);
    tgt_req = 2'b01;
    @(negedge clk);
    expect_v("rx_drq", 2, 8'h01);
    rd("rx_bsr", 5, 8'h48);
    rd("rx_dack", 0, 8'hA5, 1);
    expect_v("rx_drq_ack", 2, 8'h00);
    wait_sig("rx_ack_rise", 3, 8'h01, 10);
    tgt_req = 0;
    wait_sig("rx_ack_fall", 3, 8'h00, 10);
    expect_v("rx_drq_idle", 2, 8'h00);

    do_reset();
    tgt_bsy = 2'b01;
    wr(2, 8'h0A); wr(3, 8'h00); wr(5, 8'h00);
    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom);
      tgt_req = 2'b01;
      wait_sig("tx_drq", 2, 8'h01, 10);
      eop = (i == 1);
      wr(0, b, 1);
      expect_v("tx_dout", 5, b);
      wait_sig("tx_ack_rise", 3, 8'h01, 10);
      tgt_req = 0; eop = 0;
      wait_sig("tx_ack_fall", 3, 8'h00, 10);
    end
    rd("tx_bsr_done", 5, IRQ_ON ? 8'h98 : 8'h88);
    expect_v("tx_irq", 1, {7'b0, IRQ_ON});
    rd("tx_rpi", 7, 8'hff);
    expect_v("tx_irq_clr", 1, 8'h00);
    rd("tx_bsr_still_done", 5, 8'h80, 0, 8'h80);

    do_reset();
    tgt_bsy = 2'b01;
    wr(2, 8'h02); wr(3, 8'h00); wr(5, 8'h00);
    tgt_cd = 2'b01; tgt_req = 2'b01;
    repeat (2) @(negedge clk);
    expect_v("pm_drq", 2, 8'h00);
    rd("pm_bsr", 5, IRQ_ON ? 8'h10 : 8'h00);
    expect_v("pm_irq", 1, {7'b0, IRQ_ON});
    tgt_req = 0;
    rd("pm_rpi", 7, 8'hff);
    expect_v("pm_irq_clr", 1, 8'h00);

    do_reset();
    tgt_bsy = 2'b01;
    wr(2, 8'h06); wr(3, 8'h00); wr(5, 8'h00);
    tgt_req = 2'b01;
    wait_sig("bl_drq", 2, 8'h01, 10);
    wr(0, 8'h3C, 1);
    wait_sig("bl_ack", 3, 8'h01, 10);
    tgt_bsy = 0;
    repeat (2) @(negedge clk);
    rd("bl_bsr", 5, 8'h04, 0, 8'h04);
    expect_v("bl_irq", 1, {7'b0, IRQ_ON});
    tgt_bsy = 2'b01;
    wait_sig("bl_drq2", 2, 8'h01, 10);
    wr(0, 8'h5A, 1);
    wait_sig("bl_ack2", 3, 8'h01, 10);
    expect_v("bl_irq_held", 1, {7'b0, IRQ_ON});
    #2 reset = 1;
    #1;
    checks++;
    if (scsi_ack !== 1'b0) begin errors++; $display("FAIL ar_ack_direct: got %b", scsi_ack); end
    checks++;
    if (drq !== 1'b0) begin errors++; $display("FAIL ar_drq_direct: got %b", drq); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL ar_irq_direct: got %b", irq); end
    expect_v("ar_ack", 3, 8'h00);
    expect_v("ar_drq", 2, 8'h00);
    expect_v("ar_irq", 1, 8'h00);

    do_reset();
    tgt_bsy = 2'b11; tgt_dout = 16'h773E;
    rd("prio_data", 0, 8'h3E);
    expect_v("prio_idx", 4, 8'h00);
    tgt_bsy = 0;
    rd("idle_data", 0, 8'h55);
    expect_v("idle_idx", 4, 8'h00);

    do_reset();
    repeat (60) begin
      op = $urandom_range(0, 3);
      if (op == 0) begin
        tgt_bsy = N'($urandom); tgt_req = N'($urandom); tgt_msg = N'($urandom);
        tgt_cd = N'($urandom); tgt_io = N'($urandom); tgt_dout = (N*DW)'($urandom);
        @(negedge clk);
        a = first_busy();
        expect_v("rnd_idx", 4, (a < 0) ? 8'h00 : 8'(a));
      end else if (op == 1) begin
        rs = 3'($urandom_range(0, 3));
        d = 8'($urandom);
        if (rs == 2) d[2:1] = 2'b00;
        wr(rs, d);
        case (rs)
          0: m_odr = d;
          1: m_icr = d;
          2: m_mr = d;
          default: m_tcr = d[3:0];
        endcase
      end else if (op == 2) begin
        d = 8'($urandom);
        wr(3'($urandom), d, 1);
        m_odr = d;
        expect_v("rnd_dout", 5, d);
      end else begin
        case ($urandom_range(0, 4))
          0: rs = 0;
          1: rs = 1;
          2: rs = 4;
          3: rs = 5;
          default: rs = 6;
        endcase
        dk = $urandom_range(0, 3) == 0;
        rd("rnd_rd", rs, model_rd(rs, dk), dk);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
